// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mem_arbiter_pkg : shared types and constants for mem_arbiter   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_WAIT   = 4;
  localparam int STARVE_W       = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_tagpipe.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mem_arb_tagpipe : 2-stage read tag pipeline, per-port rvalid   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module mem_arb_tagpipe
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic       accept,
  input  logic       is_read,
  input  logic       port,
  output logic [1:0] rvalid
);

  logic       s1_valid_q, s1_valid_d;
  logic       s1_port_q, s1_port_d;
  logic [1:0] rvalid_q, rvalid_d;

  always_comb begin
    s1_valid_d           = accept && is_read;
    s1_port_d            = port;
    rvalid_d             = '0;
    rvalid_d[PORT_CPU]   = s1_valid_q && (s1_port_q == PORT_CPU);
    rvalid_d[PORT_DMA]   = s1_valid_q && (s1_port_q == PORT_DMA);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_valid_q <= 1'b0;
      s1_port_q  <= PORT_CPU;
      rvalid_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_port_q  <= s1_port_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mem_arbiter : 2-port fixed-priority RAM arbiter, anti-starve   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT       = DEF_MAX_WAIT
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      p0_req,
  input  logic                      p0_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p0_addr,
  input  logic [MEM_DATA_WIDTH-1:0] p0_wdata,
  output logic                      p0_gnt,
  output logic                      p0_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] p0_rdata,
  input  logic                      p1_req,
  input  logic                      p1_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p1_addr,
  input  logic [MEM_DATA_WIDTH-1:0] p1_wdata,
  output logic                      p1_gnt,
  output logic                      p1_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] p1_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
  output logic                      mem_WE,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_i
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

  arb_state_e                state_q, state_d;
  logic [STARVE_W-1:0]       starve_q, starve_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                      force_p1, gnt0, gnt1, accept, cmd_we;
  logic [1:0]                rvalid;

  always_comb begin
    // Grants are gated by arst so nothing is accepted while reset is held.
    force_p1 = (state_q == FORCE) && p1_req;
    gnt0     = !arst && p0_req && !force_p1;
    gnt1     = !arst && p1_req && (force_p1 || !p0_req);
    accept   = gnt0 || gnt1;
    cmd_we   = gnt1 ? p1_we : p0_we;

    starve_d = '0;
    if (p1_req && !gnt1) begin
      starve_d = (starve_q >= MAX_WAIT_C) ? MAX_WAIT_C : starve_q + STARVE_W'(1);
    end
    state_d = (starve_d == MAX_WAIT_C) ? FORCE : NORMAL;

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    if (accept) begin
      mem_addr_d = gnt1 ? p1_addr  : p0_addr;
      mem_data_d = gnt1 ? p1_wdata : p0_wdata;
      mem_we_d   = cmd_we;
    end

    // RAM data arrives in the rvalid cycle; the hold register keeps it afterwards.
    rdata0_d = rvalid[PORT_CPU] ? mem_data_i : rdata0_q;
    rdata1_d = rvalid[PORT_DMA] ? mem_data_i : rdata1_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  mem_arb_tagpipe u_tagpipe (
    .clk     (clk),
    .arst    (arst),
    .accept  (accept),
    .is_read (!cmd_we),
    .port    (gnt1 ? PORT_DMA : PORT_CPU),
    .rvalid  (rvalid)
  );

  assign p0_gnt     = gnt0;
  assign p1_gnt     = gnt1;
  assign p0_rvalid  = rvalid[PORT_CPU];
  assign p1_rvalid  = rvalid[PORT_DMA];
  assign p0_rdata   = rdata0_d;
  assign p1_rdata   = rdata1_d;
  assign mem_addr   = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_WE     = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mem_arbiter : randomized scoreboard bench for mem_arbiter   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] mem_addr, mem_data_o, mem_data_i;
  logic       mem_WE;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8), .MAX_WAIT(MW)) dut (
    .clk(clk), .arst(arst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_WE(mem_WE),
    .mem_data_i(mem_data_i)
  );

  // Single-port synchronous RAM, one cycle read latency.
  logic [7:0] ram [256];
  logic [7:0] ram_rd;
  always @(posedge clk) begin
    if (mem_WE) ram[mem_addr] <= mem_data_o;
    ram_rd <= ram[mem_addr];
  end
  assign mem_data_i = ram_rd;

  typedef struct { int due; logic we; logic [7:0] addr; logic [7:0] data; } cmd_t;
  typedef struct { int due; logic port; logic [7:0] data; } rd_t;

  cmd_t       cmd_q[$];
  rd_t        rd_q[$];
  logic [7:0] model_mem [256];
  int         m_wait = 0;
  int         cyc = 0;
  int         checks = 0, errors = 0;
  logic       mon_en = 1'b0;
  logic [7:0] last_addr = 8'h00;
  logic       s_g0, s_g1, m_g0, m_g1;
  cmd_t       mon_c;
  rd_t        mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares RAM commands and read returns against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !arst) begin
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        mon_c = cmd_q.pop_front();
        check("mem_WE", 32'(mem_WE), 32'(mon_c.we));
        check("mem_addr", 32'(mem_addr), 32'(mon_c.addr));
        if (mon_c.we) check("mem_data_o", 32'(mem_data_o), 32'(mon_c.data));
        last_addr = mon_c.addr;
      end else begin
        check("mem_WE_idle", 32'(mem_WE), 32'd0);
        check("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mon_r = rd_q.pop_front();
        check("p0_rvalid", 32'(p0_rvalid), 32'(mon_r.port == 1'b0));
        check("p1_rvalid", 32'(p1_rvalid), 32'(mon_r.port == 1'b1));
        check("rdata", 32'(mon_r.port ? p1_rdata : p0_rdata), 32'(mon_r.data));
      end else begin
        check("p0_rvalid_idle", 32'(p0_rvalid), 32'd0);
        check("p1_rvalid_idle", 32'(p1_rvalid), 32'd0);
      end
    end
  end

  // One arbitration cycle; entered and left just after a rising edge.
  task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    logic f, g0, g1;
    cmd_t c;
    rd_t  r;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    f  = r1 && (m_wait >= MW);
    g1 = r1 && (f || !r0);
    g0 = r0 && !f;
    if (r1 && !g1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else           m_wait = 0;
    @(negedge clk);
    s_g0 = p0_gnt;
    s_g1 = p1_gnt;
    check("p0_gnt", 32'(p0_gnt), 32'(g0));
    check("p1_gnt", 32'(p1_gnt), 32'(g1));
    if (g0 || g1) begin
      c.due  = cyc + 1;
      c.we   = g1 ? w1 : w0;
      c.addr = g1 ? a1 : a0;
      c.data = g1 ? d1 : d0;
      cmd_q.push_back(c);
      if (c.we) model_mem[c.addr] = c.data;
      else begin
        r.due  = cyc + 2;
        r.port = g1;
        r.data = model_mem[c.addr];
        rd_q.push_back(r);
      end
    end
    m_g0 = g0;
    m_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0_gnt"},     32'(p0_gnt),     32'd0);
    check({tag, "_p1_gnt"},     32'(p1_gnt),     32'd0);
    check({tag, "_mem_WE"},     32'(mem_WE),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_data_o"}, 32'(mem_data_o), 32'd0);
    check({tag, "_p0_rvalid"},  32'(p0_rvalid),  32'd0);
    check({tag, "_p1_rvalid"},  32'(p1_rvalid),  32'd0);
    check({tag, "_p0_rdata"},   32'(p0_rdata),   32'd0);
    check({tag, "_p1_rdata"},   32'(p1_rdata),   32'd0);
  endtask

  task automatic model_reset();
    cmd_q.delete();
    rd_q.delete();
    m_wait    = 0;
    last_addr = 8'h00;
  endtask

  logic       pend0, pend1, pw0, pw1;
  logic [7:0] pa0, pd0, pa1, pd1;

  initial begin
    arst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    arst   = 1'b0;
    mon_en = 1'b1;

    // p0 write then read-back of the same address
    step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) idle();

    // p1 alone: seed 0x20, then read it back
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
    repeat (2) idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    check("p1_gnt_alone", 32'(s_g1), 32'd1);
    repeat (3) idle();

    // Both requesting continuously: p1 wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'(8'h30 + i), 8'($urandom),
           1'b1, 1'b1, 8'(8'h40 + i / 5), 8'(8'h5A ^ (i / 5)));
      check("starve_p1_pattern", 32'(s_g1), 32'((i % 5) == 4));
      check("starve_p0_pattern", 32'(s_g0), 32'((i % 5) != 4));
      check("starve_cnt_bound", 32'(dut.starve_q <= 4'd4), 32'd1);
    end
    idle();

    // Reach FORCE, then p1 withdraws: p0 served, no forced p1 grant follows
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 8'(8'h50 + i), 8'(i), 1'b1, 1'b1, 8'h60, 8'h77);
    step(1'b1, 1'b1, 8'h54, 8'h04, 1'b0, 1'b1, 8'h60, 8'h77);
    check("force_drop_p0", 32'(s_g0), 32'd1);
    check("force_drop_p1", 32'(s_g1), 32'd0);
    step(1'b1, 1'b1, 8'h55, 8'h05, 1'b1, 1'b1, 8'h60, 8'h77);
    check("normal_after_drop", 32'(s_g0), 32'd1);
    idle();

    // Initialise the random-test address window
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 8'(a), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
    idle();

    // Randomised traffic; each requester holds its command until granted
    pend0 = 1'b0; pend1 = 1'b0;
    pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
        pa0 = 8'($urandom_range(0, 15)); pd0 = 8'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
        pa1 = 8'($urandom_range(0, 15)); pd1 = 8'($urandom);
      end
      step(pend0, pw0, pa0, pd0, pend1, pw1, pa1, pd1);
      if (m_g0) pend0 = 1'b0;
      if (m_g1) pend1 = 1'b0;
    end
    repeat (3) idle();

    // Reset one cycle after a p0 read accept; the read must vanish
    step(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    p0_req = 1'b1; p0_addr = 8'h07;
    arst = 1'b1;
    #1;
    check_all_zero("arst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (4) idle();

    // Short reset pulse, request right after release
    arst = 1'b1;
    #2;
    arst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("post_reset_gnt", 32'(s_g0), 32'd1);
    repeat (3) idle();

    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
